// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// DEPTH x DATA_WIDTH word RAM with per-byte write enables and a registered
// read port (data appears one edge after rd_en). Contents are never reset.
module axi_lite_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                           aclk,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic [$clog2(DEPTH)-1:0]       wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH)-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Byte-lane writes: each lane updated only when its enable is set.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wr_be[i]) begin
        mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Registered read; holds its value while rd_en is low.
  always_ff @(posedge aclk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave: word RAM behind the five AXI4-Lite channels with
// byte strobes and SLVERR on accesses outside the configured window.
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W (either order); commit when both are in hand
//   W_RESP | bvalid high, waiting for bready; no new AW/W accepted
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for AR
//   R_DATA | RAM read issued, then rvalid held until rready
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(DEPTH);

  // Window bounds carry one extra bit so the upper bound can equal 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(BASE_ADDR + DEPTH * STRB_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [IDX_W-1:0]      idx_t;

  function automatic logic in_window(addr_t a);
    logic [ADDR_WIDTH:0] ax;
    ax = {1'b0, a};
    return (ax >= WIN_LO) && (ax < WIN_HI);
  endfunction

  // Low alignment bits are dropped by the shift.
  function automatic idx_t word_idx(addr_t a);
    addr_t off;
    off = a - ADDR_WIDTH'(BASE_ADDR);
    return idx_t'(off >> LSB);
  endfunction

  // ---------------- write path ----------------
  wr_state_t wr_state_q, wr_state_d;
  logic      awready_q, awready_d;
  logic      wready_q, wready_d;
  logic      aw_held_q, aw_held_d;
  logic      w_held_q, w_held_d;
  addr_t     awaddr_q, awaddr_d;
  data_t     wdata_q, wdata_d;
  strb_t     wstrb_q, wstrb_d;
  logic      bvalid_q, bvalid_d;
  resp_t     bresp_q, bresp_d;

  logic  aw_hs, w_hs, aw_have, w_have;
  addr_t wr_addr_mux;
  data_t wr_data_mux;
  strb_t wr_strb_mux;
  strb_t mem_be;
  logic  mem_we;
  idx_t  wr_idx;

  assign aw_hs       = awvalid & awready_q;
  assign w_hs        = wvalid & wready_q;
  assign aw_have     = aw_held_q | aw_hs;
  assign w_have      = w_held_q | w_hs;
  assign wr_addr_mux = aw_hs ? awaddr : awaddr_q;
  assign wr_data_mux = w_hs ? wdata : wdata_q;
  assign wr_strb_mux = w_hs ? wstrb : wstrb_q;
  assign wr_idx      = word_idx(wr_addr_mux);
  assign mem_be      = wr_strb_mux & {STRB_WIDTH{mem_we}};

  // Write FSM: commit on the edge where both AW and W are in hand.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) awaddr_d = awaddr;
        if (w_hs) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_have && w_have) begin
          mem_we     = in_window(wr_addr_mux);
          wr_state_d = W_RESP;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = in_window(wr_addr_mux) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          aw_held_d = aw_have;
          w_held_d  = w_have;
          awready_d = ~aw_have;
          wready_d  = ~w_have;
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write-path registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_t rd_state_q, rd_state_d;
  logic      arready_q, arready_d;
  addr_t     araddr_q, araddr_d;
  logic      rvalid_q, rvalid_d;
  resp_t     rresp_q, rresp_d;
  logic      rd_ok_q, rd_ok_d;

  logic  ar_hs;
  logic  mem_re;
  idx_t  rd_idx;
  data_t mem_rdata;

  assign ar_hs  = arvalid & arready_q;
  assign rd_idx = word_idx(araddr_q);

  // Read FSM: the RAM read is issued one edge after AR so a write committed
  // on the AR edge is already in the array.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    araddr_d   = araddr_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rd_ok_d    = rd_ok_q;
    mem_re     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          araddr_d   = araddr;
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
        end
      end
      R_DATA: begin
        if (!rvalid_q) begin
          mem_re   = in_window(araddr_q);
          rvalid_d = 1'b1;
          rd_ok_d  = in_window(araddr_q);
          rresp_d  = in_window(araddr_q) ? RESP_OKAY : RESP_SLVERR;
        end else if (rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read-path registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      araddr_q   <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rd_ok_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      araddr_q   <= araddr_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  axi_lite_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .aclk    (aclk),
    .wr_be   (mem_be),
    .wr_idx  (wr_idx),
    .wr_data (wr_data_mux),
    .rd_en   (mem_re),
    .rd_idx  (rd_idx),
    .rd_data (mem_rdata)
  );

  // rdata is forced to zero after reset and for out-of-window reads; the
  // gate is a flop so there is no combinational path from any input.
  assign rdata   = rd_ok_q ? mem_rdata : '0;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave (32-bit data, 256 words, base 0).
module tb_axi_lite_mem_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_lite_mem_slave #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .BASE_ADDR  (0)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit got;
    got  = 0;
    resp = 2'bxx;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bvalid) begin
        resp = bresp;
        got  = 1;
      end
      tick();
    end
    bready = 1'b0;
    if (!got) timeout("b_channel");
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, awf, wf;
    int n;
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      awf = awvalid && awready;
      wf  = wvalid && wready;
      tick();
      if (awf) begin aw_done = 1; awvalid = 1'b0; end
      if (wf)  begin w_done = 1;  wvalid = 1'b0;  end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout("aw_w_channel");
      resp = 2'bxx;
      bready = 1'b0;
    end else begin
      wait_b(resp);
    end
  endtask

  task automatic ar_send(input logic [11:0] a, output bit ok);
    bit f;
    araddr = a; arvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      f = arvalid && arready;
      tick();
      if (f) ok = 1;
    end
    arvalid = 1'b0;
    if (!ok) timeout("ar_channel");
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok, got;
    d = 'x; resp = 2'bxx;
    rready = 1'b1;
    ar_send(a, ok);
    got = 0;
    for (int n = 0; n < 20 && ok && !got; n++) begin
      if (rvalid) begin
        d = rdata; resp = rresp; got = 1;
      end
      tick();
    end
    rready = 1'b0;
    if (ok && !got) timeout("r_channel");
  endtask

  // One channel first, gap cycles, then the other.
  task automatic split_write(input logic [11:0] a, input logic [31:0] d, input bit w_first,
                             input int gap, output logic [1:0] resp);
    bit fire;
    bready = 1'b1;
    if (w_first) begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
    else begin awaddr = a; awvalid = 1'b1; end
    fire = 0;
    for (int n = 0; n < 20 && !fire; n++) begin
      fire = w_first ? (wvalid && wready) : (awvalid && awready);
      tick();
    end
    wvalid = 1'b0; awvalid = 1'b0;
    if (!fire) timeout("split_first");
    for (int i = 0; i < gap; i++) begin
      check("split_no_bvalid", {31'b0, bvalid}, 32'd0);
      check("split_first_ready_low", {31'b0, (w_first ? wready : awready)}, 32'd0);
      check("split_other_ready_high", {31'b0, (w_first ? awready : wready)}, 32'd1);
      tick();
    end
    if (w_first) begin awaddr = a; awvalid = 1'b1; end
    else begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
    fire = 0;
    for (int n = 0; n < 20 && !fire; n++) begin
      fire = w_first ? (awvalid && awready) : (wvalid && wready);
      tick();
    end
    wvalid = 1'b0; awvalid = 1'b0;
    if (!fire) begin
      timeout("split_second");
      resp = 2'bxx;
    end else begin
      wait_b(resp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    bit          ok, fire;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, OKAY,   32'h0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, OKAY,   32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h030, 32'hAABBCCDD, 4'hF, OKAY,   32'h0};
    vecs[3]  = '{1'b1, 12'h030, 32'h00000055, 4'h1, OKAY,   32'h0};
    vecs[4]  = '{1'b0, 12'h030, 32'h0,        4'h0, OKAY,   32'hAABBCC55};
    vecs[5]  = '{1'b1, 12'h000, 32'h12345678, 4'hF, OKAY,   32'h0};
    vecs[6]  = '{1'b1, 12'h400, 32'hCAFEF00D, 4'hF, SLVERR, 32'h0};
    vecs[7]  = '{1'b0, 12'h400, 32'h0,        4'h0, SLVERR, 32'h0};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, OKAY,   32'h12345678};
    vecs[9]  = '{1'b1, 12'h3FC, 32'hFFFFFFFF, 4'hF, OKAY,   32'h0};
    vecs[10] = '{1'b1, 12'h3FC, 32'h0A0B0C0D, 4'hA, OKAY,   32'h0};
    vecs[11] = '{1'b0, 12'h3FC, 32'h0,        4'h0, OKAY,   32'h0AFF0CFF};
    vecs[12] = '{1'b1, 12'h037, 32'h01020304, 4'hF, OKAY,   32'h0};
    vecs[13] = '{1'b0, 12'h034, 32'h0,        4'h0, OKAY,   32'h01020304};
    vecs[14] = '{1'b1, 12'h010, 32'h00000000, 4'h0, OKAY,   32'h0};
    vecs[15] = '{1'b0, 12'h010, 32'h0,        4'h0, OKAY,   32'hDEADBEEF};
    vecs[16] = '{1'b0, 12'h3FF, 32'h0,        4'h0, OKAY,   32'h0AFF0CFF};
    vecs[17] = '{1'b0, 12'h800, 32'h0,        4'h0, SLVERR, 32'h0};
    vecs[18] = '{1'b1, 12'hFFC, 32'h11111111, 4'hF, SLVERR, 32'h0};
    vecs[19] = '{1'b0, 12'h000, 32'h0,        4'h0, OKAY,   32'h12345678};

    areset_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    #1;
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_wready",  {31'b0, wready},  32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_bvalid",  {31'b0, bvalid},  32'd0);
    check("rst_rvalid",  {31'b0, rvalid},  32'd0);
    check("rst_bresp",   {30'b0, bresp},   32'd0);
    check("rst_rresp",   {30'b0, rresp},   32'd0);
    check("rst_rdata",   rdata,            32'd0);
    repeat (3) @(posedge aclk);
    #3 areset_n = 1'b1;
    #1;
    check("rel_awready_still_low", {31'b0, awready}, 32'd0);
    tick();
    check("rel_awready_up", {31'b0, awready}, 32'd1);
    check("rel_wready_up",  {31'b0, wready},  32'd1);
    check("rel_arready_up", {31'b0, arready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, d, resp);
        check($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
      end
    end

    // W three cycles before AW, then AW before W.
    split_write(12'h020, 32'h11223344, 1'b1, 3, resp);
    check("w_first_bresp", {30'b0, resp}, 32'd0);
    axi_read(12'h020, d, resp);
    check("w_first_rdata", d, 32'h11223344);
    split_write(12'h024, 32'h99887766, 1'b0, 2, resp);
    check("aw_first_bresp", {30'b0, resp}, 32'd0);
    axi_read(12'h024, d, resp);
    check("aw_first_rdata", d, 32'h99887766);

    // Back-pressure on B: response stable, no new AW/W accepted.
    awaddr = 12'h040; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0;
    fire = 0;
    for (int n = 0; n < 20 && !fire; n++) begin
      fire = awready && wready;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!fire) timeout("stall_b_accept");
    for (int i = 0; i < 5; i++) begin
      check("stall_bvalid",  {31'b0, bvalid},  32'd1);
      check("stall_bresp",   {30'b0, bresp},   32'd0);
      check("stall_awready", {31'b0, awready}, 32'd0);
      check("stall_wready",  {31'b0, wready},  32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("stall_b_done_bvalid",  {31'b0, bvalid},  32'd0);
    check("stall_b_done_awready", {31'b0, awready}, 32'd1);

    // Back-pressure on R, plus one-edge read latency.
    rready = 1'b0;
    ar_send(12'h040, ok);
    check("rd_lat_rvalid_low", {31'b0, rvalid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid",  {31'b0, rvalid},  32'd1);
      check("stall_rdata",   rdata,            32'h0BADF00D);
      check("stall_rresp",   {30'b0, rresp},   32'd0);
      check("stall_arready", {31'b0, arready}, 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("stall_r_done_rvalid",  {31'b0, rvalid},  32'd0);
    check("stall_r_done_arready", {31'b0, arready}, 32'd1);

    // Reset while bvalid is pending.
    awaddr = 12'h050; awvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0;
    fire = 0;
    for (int n = 0; n < 20 && !fire; n++) begin
      fire = awready && wready;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!fire) timeout("rst_mid_accept");
    check("rst_mid_bvalid_before", {31'b0, bvalid}, 32'd1);
    #2 areset_n = 1'b0;
    #1;
    check("rst_mid_bvalid",  {31'b0, bvalid},  32'd0);
    check("rst_mid_awready", {31'b0, awready}, 32'd0);
    check("rst_mid_arready", {31'b0, arready}, 32'd0);
    @(posedge aclk);
    #3 areset_n = 1'b1;
    tick();
    check("rst_mid_rel_awready", {31'b0, awready}, 32'd1);
    check("rst_mid_rel_wready",  {31'b0, wready},  32'd1);
    check("rst_mid_rel_arready", {31'b0, arready}, 32'd1);
    check("rst_mid_rel_bvalid",  {31'b0, bvalid},  32'd0);
    axi_read(12'h050, d, resp);
    check("rst_mid_kept_rdata", d, 32'h5A5A5A5A);
    check("rst_mid_kept_rresp", {30'b0, resp}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
